// File: rtl/full_pipeline_pkg.sv
// rtl/full_pipeline_pkg.sv - shared widths, pixel type and Sobel helpers for the edge pipeline
package full_pipeline_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;
    localparam int MAG_W  = 12;
    localparam logic [PIX_W-1:0] MAG_MAX = 8'd255;

    typedef logic [PIX_W-1:0] pixel_t;

    function automatic logic signed [GRAD_W-1:0] ext_pix(input pixel_t p);
        return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        return g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
    endfunction

endpackage

// File: rtl/full_pipeline_top_line_buffer.sv
// rtl/full_pipeline_top_line_buffer.sv - DEPTH-deep shift RAM, registered read one line behind the write
import full_pipeline_pkg::*;

module line_buffer #(
    parameter int DEPTH = 3000
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_din,
    output logic [PIX_W-1:0] o_dout
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    pixel_t          r_mem [DEPTH];
    pixel_t          r_dout;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   w_rd_ptr;

    // Read one slot ahead so o_dout already holds the sample from DEPTH accepts
    // ago when the next pixel arrives.
    assign w_rd_ptr = (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
    assign o_dout   = r_dout;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
        end else if (i_en) begin
            r_wr_ptr <= w_rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_wr_ptr] <= i_din;
            r_dout          <= r_mem[w_rd_ptr];
        end
    end

endmodule

// File: rtl/full_pipeline_top.sv
// rtl/full_pipeline_top.sv - streaming 3x3 Sobel edge magnitude; EDGE_THRESH_EN selects binarised output
import full_pipeline_pkg::*;

module full_pipeline_top #(
    parameter int IMG_WIDTH  = 3000,
    parameter int IMG_HEIGHT = 3000,
    parameter int THRESHOLD  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] pixel,
    output logic [7:0] edge_out
);
    localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [MAG_W-1:0] TH = MAG_W'(THRESHOLD);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    pixel_t        w_lb1;
    pixel_t        w_lb2;
    pixel_t        r_p [3][3];
    logic          r_v0, r_v1;
    logic          r_border0, r_border1;
    logic [MAG_W-1:0] r_mag;

    logic signed [GRAD_W-1:0] w_gx, w_gy;
    logic [MAG_W-1:0]         w_mag;
    pixel_t                   w_sat;
    pixel_t                   w_res;

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_row1 (
        .clk    (clk),
        .i_rst  (rst),
        .i_en   (valid),
        .i_din  (pixel),
        .o_dout (w_lb1)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_row2 (
        .clk    (clk),
        .i_rst  (rst),
        .i_en   (valid),
        .i_din  (w_lb1),
        .o_dout (w_lb2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_border0 <= 1'b0;
            r_border1 <= 1'b0;
            edge_out  <= '0;
        end else begin
            r_v0 <= valid;
            r_v1 <= r_v0;
            if (valid) begin
                r_border0 <= (r_row < RW'(2)) || (r_col < CW'(2));
                if (r_col == CW'(IMG_WIDTH-1)) begin
                    r_col <= '0;
                    r_row <= (r_row == RW'(IMG_HEIGHT-1)) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (r_v0) begin
                r_border1 <= r_border0;
            end
            if (r_v1) begin
                edge_out <= r_border1 ? 8'h00 : w_res;
            end
        end
    end

    // Window and magnitude carry no reset: stale contents are masked by the border flag.
    always_ff @(posedge clk) begin
        if (valid) begin
            for (int i = 0; i < 3; i++) begin
                r_p[i][0] <= r_p[i][1];
                r_p[i][1] <= r_p[i][2];
            end
            r_p[0][2] <= w_lb2;
            r_p[1][2] <= w_lb1;
            r_p[2][2] <= pixel;
        end
        if (r_v0) begin
            r_mag <= w_mag;
        end
    end

    assign w_gx = (ext_pix(r_p[0][2]) + (ext_pix(r_p[1][2]) <<< 1) + ext_pix(r_p[2][2]))
                - (ext_pix(r_p[0][0]) + (ext_pix(r_p[1][0]) <<< 1) + ext_pix(r_p[2][0]));
    assign w_gy = (ext_pix(r_p[2][0]) + (ext_pix(r_p[2][1]) <<< 1) + ext_pix(r_p[2][2]))
                - (ext_pix(r_p[0][0]) + (ext_pix(r_p[0][1]) <<< 1) + ext_pix(r_p[0][2]));
    assign w_mag = {1'b0, abs_grad(w_gx)} + {1'b0, abs_grad(w_gy)};

    assign w_sat = (r_mag > MAG_W'(MAG_MAX)) ? MAG_MAX : r_mag[PIX_W-1:0];

`ifdef EDGE_THRESH_EN
    assign w_res = ({{(MAG_W-PIX_W){1'b0}}, w_sat} >= TH) ? 8'hFF : 8'h00;
`else
    logic w_unused_thresh;
    assign w_unused_thresh = |TH;
    assign w_res = w_sat;
`endif

endmodule

// File: tb/tb_full_pipeline_top.sv
// tb/tb_full_pipeline_top.sv - scoreboard bench for full_pipeline_top on an 8x8 frame
module tb_full_pipeline_top;
    localparam int W = 8;
    localparam int H = 8;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [7:0] pixel;
    logic [7:0] edge_out;

    logic [7:0] exp_q[$];
    logic [7:0] last_exp;
    logic [2:0] vp;
    int         checks;
    int         errors;
    int         cyc;

    full_pipeline_top #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .pixel    (pixel),
        .edge_out (edge_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tracks which edges should complete a result: accept at edge k shows after edge k+2.
    always @(posedge clk) begin
        if (rst) vp <= 3'b000;
        else     vp <= {vp[1:0], valid};
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            checks++;
            if (vp[2]) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected: got %0d, none expected", edge_out);
                end else begin
                    e = exp_q.pop_front();
                    last_exp = e;
                    if (edge_out !== e) begin
                        errors++;
                        $display("FAIL result @%0t: got %0d expected %0d", $time, edge_out, e);
                    end
                end
            end else if (edge_out !== last_exp) begin
                errors++;
                $display("FAIL hold @%0t: got %0d expected %0d", $time, edge_out, last_exp);
            end
        end
    end

    function automatic logic [7:0] expect_px(input int pat, input int v, input int r, input int c);
        int m;
        m = 0;
        if (r >= 2 && c >= 2) begin
            if (pat == 1 && (c == 4 || c == 5)) m = 4 * v;
            if (pat == 2 && (r == 4 || r == 5)) m = 4 * v;
        end
        if (m > 255) m = 255;
`ifdef EDGE_THRESH_EN
        m = (m >= 64) ? 255 : 0;
`endif
        return 8'(m);
    endfunction

    function automatic logic [7:0] pix_of(input int pat, input int v, input int r, input int c);
        if (pat == 0) return 8'h80;
        if (pat == 1) return (c >= 4) ? 8'(v) : 8'd0;
        return (r >= 4) ? 8'(v) : 8'd0;
    endfunction

    task automatic send_frame(input int pat, input int v, input bit gaps, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (gaps && (cyc % 3 == 2)) begin
                valid = 1'b0;
                @(posedge clk); #1;
                cyc++;
            end
            valid = 1'b1;
            pixel = pix_of(pat, v, i / W, i % W);
            exp_q.push_back(expect_px(pat, v, i / W, i % W));
            @(posedge clk); #1;
            cyc++;
        end
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        last_exp = 8'd0;
        checks++;
        if (edge_out !== 8'd0) begin
            errors++;
            $display("FAIL reset: got %0d expected 0", edge_out);
        end
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        last_exp = 8'd0;
        rst      = 1'b1;
        valid    = 1'b0;
        pixel    = 8'd0;
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        send_frame(0, 0,   1'b0, W*H);
        send_frame(1, 10,  1'b0, W*H);
        send_frame(1, 100, 1'b0, W*H);
        send_frame(2, 10,  1'b0, W*H);
        send_frame(1, 10,  1'b1, W*H);
        send_frame(1, 100, 1'b1, W*H);
        send_frame(1, 10,  1'b0, 20);
        do_reset();
        send_frame(1, 10,  1'b0, W*H);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
